popcount_sched: RTL and testbench
=================================

Name: popcount_sched

Overview:
- Controller that shares one 4-bit ones-counter slice between two requesters.
- Each accepted word of 4*NIBBLES bits is streamed through the slice one nibble per cycle, LSB nibble first.
- The slice's one-hot count (zero/one/two/three/four) is converted to binary and accumulated.
- The total is returned on a valid/ready result port tagged with the requester id.

Parameters:
- NIBBLES, 4, number of nibbles per word; word width DW = 4*NIBBLES; legal range 1..8.
- CW, $clog2(4*NIBBLES+1), width of the result count; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- ena  input  1  global enable; low freezes all state
- req0_valid  input  1  requester 0 has a word
- req0_data  input  DW  requester 0 word
- req0_ready  output  1  requester 0 word accepted this cycle when valid
- req1_valid  input  1  requester 1 has a word
- req1_data  input  DW  requester 1 word
- req1_ready  output  1  requester 1 word accepted this cycle when valid
- res_valid  output  1  result available
- res_ready  input  1  consumer takes result
- res_count  output  CW  number of ones in accepted word
- res_id  output  1  requester that owns the result (0/1)

Behaviour:
- Clock is clk; reset is rst_n, synchronous, active-low; one clock domain.
- Reset (rst_n=0 at a rising edge), regardless of state:
  - state=IDLE; res_valid=0; res_count=0; res_id=0.
  - Accumulator=0; nibble index=0; last-grant pointer=1, so req0 wins the first tie.
- ena=0: no state, register or pointer changes; req0_ready=req1_ready=0; res_valid/res_count/res_id hold.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - reqN_ready=1 combinationally only for the granted requester, when ena=1 and that requester's valid=1.
  - Grant rule: only one valid -> that one; both valid -> the one not equal to last-grant pointer (round-robin).
  - Transfer on valid&ready: capture data into shift register; id reg=grant; pointer=grant; acc=0; index=0; -> RUN.
  - Both readies never high in the same cycle.
- RUN, one cycle per nibble:
  - The slice sees shreg[3:0]; its one-hot output is encoded to 0..4.
  - acc <= acc + encoded; shreg >>= 4; index++.
  - On the cycle index==NIBBLES-1 the final add completes; -> DONE, res_count <= final sum, res_id <= id reg, res_valid <= 1.
  - Both readies=0 during RUN and DONE; requests wait and are not dropped.
- DONE:
  - res_valid=1 with stable count/id until res_ready=1 at a rising edge.
  - Then res_valid <= 0 -> IDLE. No new word is accepted in that same cycle.
- Latency: accept at edge T -> res_valid high after edge T+NIBBLES. Minimum spacing between accepts is NIBBLES+2 cycles.
- Width: acc is CW bits; the maximum of 4*NIBBLES fits, so no overflow. The encoded slice value is 3 bits, zero-extended.
- The slice output must be one-hot; a non-one-hot pattern is encoded as 0 (defensive; unreachable in correct logic).
- Reset mid-RUN or mid-DONE: word and result are discarded, with no res_valid pulse. The requester must re-present its word.
- Pointer updates only on an accepted transfer, never on reset-free idle cycles.

Optional Feature:
- Macro: POPCOUNT_SCHED_MAJORITY_EN.
- Defined:
  - Adds output res_major (1 bit), registered alongside res_count.
  - res_major=1 iff res_count > 2*NIBBLES (strict majority of ones).
  - Reset value 0; holds with res_valid; frozen by ena=0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then single request: req0 data=16'hF0F1 (NIBBLES=4).
  - req0_ready pulses one cycle.
  - res_valid rises 4 cycles after accept with res_count=9, res_id=0.
  - Held with res_ready=0 for 3 cycles, unchanged; cleared one cycle after res_ready=1.
- Tie arbitration: both valid from reset with req0=16'hFFFF, req1=16'h0001.
  - First result count=16, id=0; second result count=1, id=1.
  - Keep both valid: grants alternate 0,1,0,1.
- Boundaries: req1 data=16'h0000 -> count=0; data=16'hFFFF -> count=16. With MAJORITY_EN: res_major=0 and 1 respectively; data=16'h00FF (count=8) -> res_major=0.
- ena stall: drop ena for 5 cycles during RUN after the second nibble.
  - Result is still correct (data=16'h1234 -> count=5).
  - Latency is extended by exactly 5 cycles; readies stay 0 throughout.
- Reset mid-operation: assert rst_n=0 for 1 cycle during RUN.
  - No res_valid appears; outputs are all 0.
  - Next tie grants req0 first.
- Backpressure: req0 is held valid while in DONE with res_ready=0 for 10 cycles.
  - req0_ready stays 0 throughout.
  - Accept occurs in the first IDLE cycle after the result is consumed.

Source files
------------

// File: rtl/popcount_sched.sv
// popcount_sched: two requesters share one 4-bit ones-counter slice; words are
// streamed LSB nibble first and the count is returned tagged with the owner id.
// Optional: define POPCOUNT_SCHED_MAJORITY_EN to add the registered res_major output.
module popcount_sched #(
   parameter  int unsigned NIBBLES = 4,
   localparam int unsigned DW      = 4 * NIBBLES,
   localparam int unsigned CW      = $clog2(4 * NIBBLES + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          req0_valid,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [CW-1:0] res_count,
   output logic          res_id
`ifdef POPCOUNT_SCHED_MAJORITY_EN
   ,
   output logic          res_major
`endif
);

   localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [DW-1:0] shreg;
   logic [CW-1:0] acc;
   logic [IW-1:0] idx;
   logic          ptr;
   logic          id_reg;

   logic          grant_c;
   logic          load_c;
   logic          step_c;
   logic          finish_c;
   logic          consume_c;
   logic [4:0]    onehot_c;
   logic [2:0]    enc_c;
   logic [CW-1:0] sum_c;

   // Shared ones-counter slice: one-hot result, bit k set when the nibble holds k ones.
   function automatic logic [4:0] slice_onehot(input logic [3:0] nib);
      logic [2:0] ones;
      ones = 3'(nib[0]) + 3'(nib[1]) + 3'(nib[2]) + 3'(nib[3]);
      return 5'(1) << ones;
   endfunction

   // One-hot to binary; anything not one-hot is treated as zero ones.
   function automatic logic [2:0] onehot_enc(input logic [4:0] oh);
      logic [2:0] val;
      case (oh)
         5'b00001: val = 3'd0;
         5'b00010: val = 3'd1;
         5'b00100: val = 3'd2;
         5'b01000: val = 3'd3;
         5'b10000: val = 3'd4;
         default:  val = 3'd0;
      endcase
      return val;
   endfunction

   always_comb begin
      onehot_c = slice_onehot(shreg[3:0]);
      enc_c    = onehot_enc(onehot_c);
      sum_c    = acc + CW'(enc_c);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic; everything freezes while ena is low.
   always_comb begin
      state_nx = state;
      if (ena) begin
         case (state)
            IDLE:    if (load_c)    state_nx = RUN;
            RUN:     if (finish_c)  state_nx = DONE;
            DONE:    if (consume_c) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Output / control decode. Round-robin: on a tie grant the side not granted last.
   always_comb begin
      grant_c    = req1_valid & (~req0_valid | ~ptr);
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      load_c     = 1'b0;
      step_c     = 1'b0;
      finish_c   = 1'b0;
      consume_c  = 1'b0;
      if (ena) begin
         case (state)
            IDLE: begin
               req0_ready = req0_valid & ~grant_c;
               req1_ready = req1_valid & grant_c;
               load_c     = req0_ready | req1_ready;
            end
            RUN: begin
               step_c   = 1'b1;
               finish_c = (idx == IW'(NIBBLES - 1));
            end
            DONE: begin
               consume_c = res_ready;
            end
            default: ;
         endcase
      end
   end

   // Datapath and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg     <= '0;
         acc       <= '0;
         idx       <= '0;
         ptr       <= 1'b1;
         id_reg    <= 1'b0;
         res_valid <= 1'b0;
         res_count <= '0;
         res_id    <= 1'b0;
      end else begin
         if (load_c) begin
            shreg  <= grant_c ? req1_data : req0_data;
            id_reg <= grant_c;
            ptr    <= grant_c;
            acc    <= '0;
            idx    <= '0;
         end
         if (step_c) begin
            acc   <= sum_c;
            shreg <= shreg >> 4;
            idx   <= idx + IW'(1);
         end
         if (finish_c) begin
            res_valid <= 1'b1;
            res_count <= sum_c;
            res_id    <= id_reg;
         end
         if (consume_c) begin
            res_valid <= 1'b0;
         end
      end
   end

`ifdef POPCOUNT_SCHED_MAJORITY_EN
   // Strict majority of ones, captured with the final sum.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_major <= 1'b0;
      end else if (finish_c) begin
         res_major <= (sum_c > CW'(2 * NIBBLES));
      end
   end
`endif

endmodule

// File: tb/tb_popcount_sched.sv
// Self-checking bench for popcount_sched: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_popcount_sched;
   localparam int unsigned NIBBLES = 4;
   localparam int unsigned DW      = 16;
   localparam int unsigned CW      = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ena;
   logic          req0_valid;
   logic [DW-1:0] req0_data;
   logic          req0_ready;
   logic          req1_valid;
   logic [DW-1:0] req1_data;
   logic          req1_ready;
   logic          res_valid;
   logic          res_ready;
   logic [CW-1:0] res_count;
   logic          res_id;
`ifdef POPCOUNT_SCHED_MAJORITY_EN
   logic          res_major;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   popcount_sched #(.NIBBLES(NIBBLES)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_count  (res_count),
      .res_id     (res_id)
`ifdef POPCOUNT_SCHED_MAJORITY_EN
      ,
      .res_major  (res_major)
`endif
   );

   typedef struct {
      bit            id;
      logic [DW-1:0] data;
      int            exp_cnt;
      bit            exp_maj;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change at posedge+2, outputs are sampled at posedge+3.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      ena        = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data  = '0;
      req1_data  = '0;
      res_ready  = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   function automatic logic get_major();
`ifdef POPCOUNT_SCHED_MAJORITY_EN
      return res_major;
`else
      return 1'b0;
`endif
   endfunction

   // One isolated transaction; returns latency from accept to res_valid.
   task automatic xact(input bit id, input logic [DW-1:0] d, output int lat,
                       output logic [CW-1:0] cnt, output logic rid, output logic maj);
      int n;
      if (id) begin req1_valid = 1'b1; req1_data = d; end
      else    begin req0_valid = 1'b1; req0_data = d; end
      #1;
      n = 0;
      while (!(id ? req1_ready : req0_ready) && n < 50) begin tick(); #1; n++; end
      if (n >= 50) chk("accept_timeout", 1, 0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      lat = 0;
      #1;
      while (!res_valid && lat < 50) begin tick(); #1; lat++; end
      if (lat >= 50) chk("result_timeout", 1, 0);
      cnt = res_count;
      rid = res_id;
      maj = get_major();
   endtask

   int            lat;
   logic [CW-1:0] cnt;
   logic          rid;
   logic          maj;
   int            grants[4];
   int            rcnt[4];
   int            rids[4];
   int            ng;
   int            nr;

   initial begin
      vecs[0] = '{1'b0, 16'hF0F1, 9,  1'b1};
      vecs[1] = '{1'b1, 16'h0000, 0,  1'b0};
      vecs[2] = '{1'b1, 16'hFFFF, 16, 1'b1};
      vecs[3] = '{1'b0, 16'h00FF, 8,  1'b0};
      vecs[4] = '{1'b1, 16'h1234, 5,  1'b0};
      vecs[5] = '{1'b0, 16'h8001, 2,  1'b0};
      vecs[6] = '{1'b1, 16'h7FFF, 15, 1'b1};
      vecs[7] = '{1'b0, 16'h0F0F, 8,  1'b0};

      // Reset state
      do_reset();
      #1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_count", res_count, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_major", get_major(), 0);

      // Single request: ready pulse, latency, hold under backpressure, clear
      req0_valid = 1'b1;
      req0_data  = 16'hF0F1;
      #1;
      chk("s1_ready0", req0_ready, 1);
      chk("s1_ready1", req1_ready, 0);
      tick();
      #1;
      chk("s1_ready0_pulse", req0_ready, 0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         #1;
         chk("s1_valid_timing", res_valid, (i == 4) ? 1 : 0);
         chk("s1_ready_run", req0_ready, 0);
      end
      req0_valid = 1'b0;
      chk("s1_count", res_count, 9);
      chk("s1_id", res_id, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         chk("s1_hold_valid", res_valid, 1);
         chk("s1_hold_count", res_count, 9);
         chk("s1_hold_id", res_id, 0);
      end
      res_ready = 1'b1;
      tick();
      #1;
      chk("s1_cleared", res_valid, 0);
      res_ready = 1'b0;

      // Table-driven vectors
      do_reset();
      for (int i = 0; i < 8; i++) begin
         xact(vecs[i].id, vecs[i].data, lat, cnt, rid, maj);
         chk("vec_count", cnt, vecs[i].exp_cnt);
         chk("vec_id", rid, vecs[i].id);
         chk("vec_latency", lat, NIBBLES);
`ifdef POPCOUNT_SCHED_MAJORITY_EN
         chk("vec_major", maj, vecs[i].exp_maj);
`endif
         res_ready = 1'b1;
         tick();
         #1;
         chk("vec_cleared", res_valid, 0);
         res_ready = 1'b0;
      end

      // Tie arbitration with both requesters held valid
      do_reset();
      req0_valid = 1'b1; req0_data = 16'hFFFF;
      req1_valid = 1'b1; req1_data = 16'h0001;
      res_ready  = 1'b1;
      ng = 0; nr = 0;
      for (int c = 0; c < 80 && ng < 4; c++) begin
         #1;
         chk("tie_one_ready", req0_ready & req1_ready, 0);
         if (req0_ready || req1_ready) begin grants[ng] = int'(req1_ready); ng++; end
         if (res_valid && nr < 4) begin rcnt[nr] = int'(res_count); rids[nr] = int'(res_id); nr++; end
         tick();
      end
      chk("tie_grant_count", ng, 4);
      chk("tie_result_count", (nr >= 2) ? 1 : 0, 1);
      for (int i = 0; i < 4; i++) chk("tie_grant_order", (i < ng) ? grants[i] : -1, i % 2);
      chk("tie_r0_count", (nr > 0) ? rcnt[0] : -1, 16);
      chk("tie_r0_id", (nr > 0) ? rids[0] : -1, 0);
      chk("tie_r1_count", (nr > 1) ? rcnt[1] : -1, 1);
      chk("tie_r1_id", (nr > 1) ? rids[1] : -1, 1);

      // ena stall for 5 cycles after the second nibble
      do_reset();
      req0_valid = 1'b1; req0_data = 16'h1234;
      #1;
      chk("stall_accept", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      lat = 0;
      tick(); lat++;
      tick(); lat++;
      ena = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1; req1_data = 16'hAAAA;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_ready0", req0_ready, 0);
         chk("stall_ready1", req1_ready, 0);
         chk("stall_valid", res_valid, 0);
         tick(); lat++;
         #1;
      end
      ena = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      while (!res_valid && lat < 60) begin tick(); #1; lat++; end
      chk("stall_latency", lat, NIBBLES + 5);
      chk("stall_count", res_count, 5);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Reset during RUN discards the word; pointer returns to its reset value
      do_reset();
      req0_valid = 1'b1; req0_data = 16'hFFFF;
      #1;
      tick();
      req0_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("mid_rst_valid", res_valid, 0);
      chk("mid_rst_count", res_count, 0);
      chk("mid_rst_id", res_id, 0);
      for (int i = 0; i < NIBBLES + 3; i++) begin
         tick();
         #1;
         chk("mid_rst_no_result", res_valid, 0);
      end
      req0_valid = 1'b1; req0_data = 16'h0003;
      req1_valid = 1'b1; req1_data = 16'h0007;
      #1;
      chk("mid_rst_tie_r0", req0_ready, 1);
      chk("mid_rst_tie_r1", req1_ready, 0);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      lat = 0;
      #1;
      while (!res_valid && lat < 50) begin tick(); #1; lat++; end
      chk("mid_rst_after_count", res_count, 2);
      chk("mid_rst_after_id", res_id, 0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Backpressure in DONE keeps the next request waiting
      do_reset();
      xact(1'b0, 16'h00F0, lat, cnt, rid, maj);
      chk("bp_first_count", cnt, 4);
      req0_valid = 1'b1; req0_data = 16'h0007;
      #1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_ready_held", req0_ready, 0);
         chk("bp_valid_held", res_valid, 1);
         tick();
         #1;
      end
      res_ready = 1'b1;
      #1;
      chk("bp_ready_consume_cycle", req0_ready, 0);
      tick();
      res_ready = 1'b0;
      #1;
      chk("bp_cleared", res_valid, 0);
      chk("bp_accept_first_idle", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      lat = 0;
      #1;
      while (!res_valid && lat < 50) begin tick(); #1; lat++; end
      chk("bp_second_count", res_count, 3);
      chk("bp_second_latency", lat, NIBBLES);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Randomized traffic against a transaction-level model
      do_reset();
      begin
         bit            v0 = 1'b0, v1 = 1'b0;
         logic [DW-1:0] d0 = '0, d1 = '0;
         bit            m_busy = 1'b0, m_pend = 1'b0, m_last = 1'b1;
         int            m_left = 0, e_cnt = 0;
         bit            e_id = 1'b0, e_r0, e_r1;
         for (int c = 0; c < 3000; c++) begin
            if (!v0 && $urandom_range(0, 2) == 0) begin v0 = 1'b1; d0 = DW'($urandom); end
            if (!v1 && $urandom_range(0, 2) == 0) begin v1 = 1'b1; d1 = DW'($urandom); end
            req0_valid = v0; req0_data = d0;
            req1_valid = v1; req1_data = d1;
            ena        = ($urandom_range(0, 9) != 0);
            res_ready  = $urandom_range(0, 1) != 0;
            #1;
            e_r0 = ena && !m_busy && v0 && (!v1 || m_last);
            e_r1 = ena && !m_busy && v1 && (!v0 || !m_last);
            chk("rnd_ready0", req0_ready, e_r0);
            chk("rnd_ready1", req1_ready, e_r1);
            chk("rnd_res_valid", res_valid, m_pend);
            if (m_pend) begin
               chk("rnd_count", res_count, e_cnt);
               chk("rnd_id", res_id, e_id);
`ifdef POPCOUNT_SCHED_MAJORITY_EN
               chk("rnd_major", res_major, (e_cnt > 2 * NIBBLES) ? 1 : 0);
`endif
            end
            if (e_r0 || e_r1) begin
               m_busy = 1'b1;
               m_left = NIBBLES;
               e_id   = e_r1;
               e_cnt  = e_r1 ? $countones(d1) : $countones(d0);
               m_last = e_r1;
               if (e_r1) v1 = 1'b0; else v0 = 1'b0;
            end else if (ena && m_busy && !m_pend) begin
               m_left--;
               if (m_left == 0) m_pend = 1'b1;
            end else if (ena && m_pend && res_ready) begin
               m_pend = 1'b0;
               m_busy = 1'b0;
            end
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
